// File: rtl/motor_pwm_driver.sv
// motor_pwm_driver: dual-channel H-bridge PWM driver with shared period counter, period-boundary command shadowing and reversal dead time
// Ports: clk, rst (async active-high); directie_driverA/B [1:0] direction commands (10 fwd, 01 rev, 00 stop, 11 invalid);
//   factor_dc_driverA/B [11:0] duty compare values; in1_X/in2_X bridge direction pins; pwm_X bridge enable;
//   period_start one-cycle period marker; dead_X dead-time indicator; cmd_err sticky invalid-code flag.
// Optional feature macro SOFT_RAMP_EN: duty ramps toward the target by RAMP_STEP per period.
// All outputs are registered from the current counter/channel state, so they trail the counter by one cycle.
module motor_pwm_driver #(
  parameter logic [11:0] PERIOD_MAX   = 12'h999,
  parameter int          DEAD_PERIODS = 2,
  parameter logic [11:0] RAMP_STEP    = 12'h040
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  directie_driverA,
  input  logic [1:0]  directie_driverB,
  input  logic [11:0] factor_dc_driverA,
  input  logic [11:0] factor_dc_driverB,
  output logic        in1_A,
  output logic        in2_A,
  output logic        in1_B,
  output logic        in2_B,
  output logic        pwm_A,
  output logic        pwm_B,
  output logic        period_start,
  output logic        dead_A,
  output logic        dead_B,
  output logic        cmd_err
);
  typedef enum logic {RUN, DEAD} state_t;
  logic [11:0] r_cnt;
  logic        r_period_start;
  logic        r_cmd_err;
  logic        w_wrap;
  logic [1:0]  w_dir_in  [2];
  logic [11:0] w_duty_in [2];
  logic [1:0]  w_pins    [2];
  logic        w_pwm     [2];
  logic        w_dead    [2];
  assign w_wrap       = r_cnt == PERIOD_MAX;
  assign w_dir_in[0]  = directie_driverA;
  assign w_dir_in[1]  = directie_driverB;
  assign w_duty_in[0] = factor_dc_driverA;
  assign w_duty_in[1] = factor_dc_driverB;
`ifdef SOFT_RAMP_EN
  // Step toward tgt by at most RAMP_STEP; differences are taken in the safe direction so nothing wraps.
  function automatic logic [11:0] f_ramp(input logic [11:0] cur, input logic [11:0] tgt);
    return (cur < tgt) ? ((tgt - cur > RAMP_STEP) ? cur + RAMP_STEP : tgt)
                       : ((cur - tgt > RAMP_STEP) ? cur - RAMP_STEP : tgt);
  endfunction
`else
  logic w_unused_ramp;
  assign w_unused_ramp = ^RAMP_STEP;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt          <= '0;
      r_period_start <= 1'b0;
      r_cmd_err      <= 1'b0;
    end else begin
      r_cnt          <= w_wrap ? '0 : r_cnt + 12'd1;
      r_period_start <= r_cnt == '0;
      if (w_wrap && (&directie_driverA || &directie_driverB)) r_cmd_err <= 1'b1;
    end
  end
  for (genvar g = 0; g < 2; g++) begin : g_ch
    state_t      r_state;
    logic [1:0]  r_dir;
    logic [11:0] r_duty;
    logic [7:0]  r_dcnt;
    logic [1:0]  r_pins;
    logic        r_pwm;
    logic        r_dead;
    logic [1:0]  w_tgt;
    logic [11:0] w_keep;
    logic [11:0] w_fresh;
    // Invalid code 11 coasts like 00.
    assign w_tgt = &w_dir_in[g] ? 2'b00 : w_dir_in[g];
`ifdef SOFT_RAMP_EN
    assign w_keep  = (w_tgt == 2'b00) ? '0 : f_ramp(r_duty, w_duty_in[g]);
    assign w_fresh = (w_tgt == 2'b00) ? '0 : f_ramp('0, w_duty_in[g]);
`else
    assign w_keep  = w_duty_in[g];
    assign w_fresh = w_duty_in[g];
`endif
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_state <= RUN;
        r_dir   <= 2'b00;
        r_duty  <= '0;
        r_dcnt  <= '0;
        r_pins  <= 2'b00;
        r_pwm   <= 1'b0;
        r_dead  <= 1'b0;
      end else begin
        r_pins <= (r_state == RUN) ? r_dir : 2'b00;
        r_pwm  <= (r_state == RUN) && (r_dir != 2'b00) && (r_cnt < r_duty);
        r_dead <= r_state == DEAD;
        if (w_wrap) begin
          if (r_state == RUN) begin
            if (w_tgt == r_dir) begin
              r_duty <= w_keep;
            end else if (w_tgt == 2'b00 || r_dir == 2'b00 || DEAD_PERIODS == 0) begin
              r_dir  <= w_tgt;
              r_duty <= w_fresh;
            end else begin
              r_state <= DEAD;
              r_dcnt  <= 8'(DEAD_PERIODS - 1);
              r_dir   <= 2'b00;
              r_duty  <= '0;
            end
          end else if (w_tgt == 2'b00 || r_dcnt == '0) begin
            r_state <= RUN;
            r_dir   <= w_tgt;
            r_duty  <= w_fresh;
          end else begin
            r_dcnt <= r_dcnt - 8'd1;
          end
        end
      end
    end
    assign w_pins[g] = r_pins;
    assign w_pwm[g]  = r_pwm;
    assign w_dead[g] = r_dead;
  end
  assign in1_A        = w_pins[0][1];
  assign in2_A        = w_pins[0][0];
  assign in1_B        = w_pins[1][1];
  assign in2_B        = w_pins[1][0];
  assign pwm_A        = w_pwm[0];
  assign pwm_B        = w_pwm[1];
  assign dead_A       = w_dead[0];
  assign dead_B       = w_dead[1];
  assign period_start = r_period_start;
  assign cmd_err      = r_cmd_err;
endmodule

// File: tb/tb_motor_pwm_driver.sv
// tb_motor_pwm_driver: scoreboard bench for motor_pwm_driver (PERIOD_MAX=9, DEAD_PERIODS=2, RAMP_STEP=2)
module tb_motor_pwm_driver;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  dir_a = 2'b00;
  logic [1:0]  dir_b = 2'b00;
  logic [11:0] duty_a = '0;
  logic [11:0] duty_b = '0;
  logic in1_A, in2_A, in1_B, in2_B, pwm_A, pwm_B, period_start, dead_A, dead_B, cmd_err;

  motor_pwm_driver #(.PERIOD_MAX(12'h009), .DEAD_PERIODS(2), .RAMP_STEP(12'h002)) dut (
    .clk(clk), .rst(rst),
    .directie_driverA(dir_a), .directie_driverB(dir_b),
    .factor_dc_driverA(duty_a), .factor_dc_driverB(duty_b),
    .in1_A(in1_A), .in2_A(in2_A), .in1_B(in1_B), .in2_B(in2_B),
    .pwm_A(pwm_A), .pwm_B(pwm_B), .period_start(period_start),
    .dead_A(dead_A), .dead_B(dead_B), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         w;
    int         ha;
    int         hb;
    logic [1:0] pa;
    logic [1:0] pb;
    logic       da;
    logic       db;
    logic       err;
  } exp_t;

  exp_t q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int sw      = 0;
  int wcount  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: a window opens on each period_start; when the next one arrives the window is closed
  // and checked against the scoreboard entry queued for it.
  initial begin
    exp_t e;
    int ca, cb;
    logic [1:0] spa, spb;
    logic sda, sdb, serr, chg, active;
    active = 1'b0; ca = 0; cb = 0; spa = '0; spb = '0; sda = 0; sdb = 0; serr = 0; chg = 0;
    forever begin
      @(negedge clk);
      if (rst) active = 1'b0;
      else begin
        if (period_start) begin
          if (active && q.size() > 0 && q[0].w == wcount) begin
            e = q.pop_front();
            chk($sformatf("w%0d pwm_A high cycles", wcount), ca, e.ha);
            chk($sformatf("w%0d pwm_B high cycles", wcount), cb, e.hb);
            chk($sformatf("w%0d pins_A", wcount), spa, e.pa);
            chk($sformatf("w%0d pins_B", wcount), spb, e.pb);
            chk($sformatf("w%0d dead_A", wcount), sda, e.da);
            chk($sformatf("w%0d dead_B", wcount), sdb, e.db);
            chk($sformatf("w%0d cmd_err", wcount), serr, e.err);
            chk($sformatf("w%0d pins/dead stable", wcount), chg, 0);
          end
          wcount++;
          active = 1'b1;
          ca = 0; cb = 0; chg = 0;
          spa = {in1_A, in2_A}; spb = {in1_B, in2_B};
          sda = dead_A; sdb = dead_B; serr = cmd_err;
        end
        if (active) begin
          ca += int'(pwm_A);
          cb += int'(pwm_B);
          chg |= ({in1_A, in2_A} != spa) || ({in1_B, in2_B} != spb) || (dead_A != sda) || (dead_B != sdb);
        end
      end
    end
  end

  task automatic next_window();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!period_start && n < 40);
    if (!period_start) begin
      n_tests++;
      n_fail++;
      $display("FAIL period_start timeout: got 0 expected 1");
    end
    sw++;
  endtask

  // Drive commands (after dly cycles into the current window) and queue the result expected one window later.
  task automatic apply(input int dly, input logic [1:0] a, input logic [11:0] fa, input logic [1:0] b, input logic [11:0] fb,
                       input int ha, input int hb, input logic [1:0] pa, input logic [1:0] pb,
                       input logic xa, input logic xb, input logic er);
    exp_t e;
    repeat (dly) @(negedge clk);
    dir_a = a; duty_a = fa; dir_b = b; duty_b = fb;
    e = '{sw + 1, ha, hb, pa, pb, xa, xb, er};
    q.push_back(e);
    next_window();
  endtask

  function automatic logic [9:0] outs();
    return {in1_A, in2_A, in1_B, in2_B, pwm_A, pwm_B, period_start, dead_A, dead_B, cmd_err};
  endfunction

  initial begin
    exp_t e0;
    repeat (3) @(negedge clk);
    chk("outputs during reset", outs(), 0);
    e0 = '{1, 0, 0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
    q.push_back(e0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("period_start after first edge", period_start, 1);
    next_window();
`ifdef SOFT_RAMP_EN
    apply(0, 2'b10, 12'd7, 2'b10, 12'd3, 2, 2, 2'b10, 2'b10, 0, 0, 0);
    apply(0, 2'b10, 12'd7, 2'b10, 12'd3, 4, 3, 2'b10, 2'b10, 0, 0, 0);
    apply(0, 2'b10, 12'd7, 2'b10, 12'd3, 6, 3, 2'b10, 2'b10, 0, 0, 0);
    apply(0, 2'b10, 12'd7, 2'b10, 12'd3, 7, 3, 2'b10, 2'b10, 0, 0, 0);
    apply(2, 2'b10, 12'd7, 2'b10, 12'd3, 7, 3, 2'b10, 2'b10, 0, 0, 0);
    apply(0, 2'b10, 12'd3, 2'b10, 12'd3, 5, 3, 2'b10, 2'b10, 0, 0, 0);
    apply(0, 2'b10, 12'd3, 2'b10, 12'd3, 3, 3, 2'b10, 2'b10, 0, 0, 0);
    apply(0, 2'b00, 12'd7, 2'b10, 12'd3, 0, 3, 2'b00, 2'b10, 0, 0, 0);
    apply(0, 2'b01, 12'd7, 2'b11, 12'd3, 2, 0, 2'b01, 2'b00, 0, 0, 1);
`else
    apply(0, 2'b10, 12'd5,   2'b10, 12'd3, 5,  3, 2'b10, 2'b10, 0, 0, 0);
    apply(2, 2'b10, 12'd8,   2'b10, 12'd3, 8,  3, 2'b10, 2'b10, 0, 0, 0);
    apply(0, 2'b01, 12'd6,   2'b10, 12'd3, 0,  3, 2'b00, 2'b10, 1, 0, 0);
    apply(0, 2'b01, 12'd6,   2'b10, 12'd3, 0,  3, 2'b00, 2'b10, 1, 0, 0);
    apply(0, 2'b01, 12'd6,   2'b10, 12'd3, 6,  3, 2'b01, 2'b10, 0, 0, 0);
    apply(0, 2'b10, 12'd4,   2'b10, 12'd3, 0,  3, 2'b00, 2'b10, 1, 0, 0);
    apply(0, 2'b00, 12'd4,   2'b10, 12'd3, 0,  3, 2'b00, 2'b10, 0, 0, 0);
    apply(0, 2'b10, 12'hFFF, 2'b11, 12'd3, 10, 0, 2'b10, 2'b00, 0, 0, 1);
    apply(0, 2'b10, 12'd0,   2'b10, 12'd9, 0,  9, 2'b10, 2'b10, 0, 0, 1);
    apply(0, 2'b01, 12'd9,   2'b01, 12'd9, 0,  0, 2'b00, 2'b00, 1, 1, 1);
    apply(0, 2'b10, 12'd2,   2'b01, 12'd9, 0,  0, 2'b00, 2'b00, 1, 1, 1);
    apply(0, 2'b01, 12'd7,   2'b01, 12'd1, 7,  1, 2'b01, 2'b01, 0, 0, 1);
`endif
    next_window();
    @(negedge clk);
    chk("scoreboard drained", q.size(), 0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("outputs right after async reset", outs(), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("period_start after reset release", period_start, 1);
    chk("cmd_err cleared by reset", cmd_err, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
